// File: rtl/tile_scratchpad_pkg.sv
// Shared constants, host-FSM state type and perf-counter address helper for tile_scratchpad.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package Config;

    localparam int SPAD_ROW_W  = 128;
    localparam int SPAD_WORD_W = 32;
    localparam int SPAD_WORDS  = SPAD_ROW_W / SPAD_WORD_W;

    typedef enum logic [1:0] {
        SPAD_IDLE = 2'd0,
        SPAD_PEND = 2'd1,
        SPAD_RESP = 2'd2
    } spad_state_e;

    // Byte offset of the perf counter inside the host window: first byte past the RAM.
    function automatic logic [31:0] spad_perf_ofs(input int unsigned depth);
        return 32'(depth) * 32'd16;
    endfunction

endpackage

// File: rtl/tile_scratchpad_ram.sv
// Single-port DEPTH x 128 RAM with per-32-bit-word write enables, written as inferable block RAM.
// Latency: read data registered, valid the cycle after en with we==0; writes commit at the clock edge.
// Backpressure: none; accepts one access every cycle.
module spad_ram
    import Config::*;
#(
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic [SPAD_WORDS-1:0] we_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [SPAD_ROW_W-1:0] wdata_i,
    output logic [SPAD_ROW_W-1:0] rdata_o
);

    logic [SPAD_ROW_W-1:0] mem_q [DEPTH];
    logic [SPAD_ROW_W-1:0] rdata_q;

    // Word-masked write; a read (no enables) refreshes the output register.
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int i = 0; i < SPAD_WORDS; i++) begin
                if (we_i[i]) begin
                    mem_q[addr_i][i*SPAD_WORD_W +: SPAD_WORD_W] <= wdata_i[i*SPAD_WORD_W +: SPAD_WORD_W];
                end
            end
            if (we_i == '0) begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tile_scratchpad.sv
// Tile scratchpad: 128-bit accelerator port plus 32-bit host side door sharing one single-port RAM.
// Latency: accelerator read 1 cycle; host access best case 2 cycles (sys_en -> issue -> sys_ready).
// Backpressure: accelerator always owns the port; host waits in PEND (sys_busy) while acc_en is high.
// Optional: TILE_SPAD_PERF_EN adds a host-visible saturating contention counter at SYS_BASE + DEPTH*16.
module tile_scratchpad
    import Config::*;
#(
    parameter int          DEPTH    = 1024,
    parameter logic [31:0] ACC_BASE = 32'h0000_0000,
    parameter logic [31:0] SYS_BASE = 32'h4000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   acc_en,
    input  logic                   acc_rdwr,
    input  logic [31:0]            acc_addr,
    input  logic [4:0]             acc_control,
    input  logic [SPAD_ROW_W-1:0]  acc_wr_data,
    output logic [SPAD_ROW_W-1:0]  acc_rd_data,
    input  logic                   sys_en,
    input  logic                   sys_rdwr,
    input  logic [31:0]            sys_addr,
    input  logic [SPAD_WORD_W-1:0] sys_wr_data,
    output logic [SPAD_WORD_W-1:0] sys_rd_data,
    output logic                   sys_ready,
    output logic                   sys_busy,
    output logic                   err
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = spad_perf_ofs(DEPTH);

    // Accelerator decode
    logic [31:0] acc_ofs;
    logic        acc_in_rng;
    logic        acc_access;
    logic        acc_rd;

    assign acc_ofs    = acc_addr - ACC_BASE;
    assign acc_in_rng = (acc_addr >= ACC_BASE) && (acc_ofs < SPAN);
    // A write with no word enables is a no-op and must not flag an error.
    assign acc_access = acc_en && (!acc_rdwr || (acc_control[3:0] != 4'd0));
    assign acc_rd     = acc_en && !acc_rdwr;

    // Host holding registers and decode (from captured address)
    spad_state_e            state_q, state_d;
    logic [31:0]            sys_addr_q;
    logic [SPAD_WORD_W-1:0] sys_wdat_q;
    logic                   sys_wr_q;
    logic [31:0]            host_ofs;
    logic                   host_in_rng;
    logic                   host_perf;
    logic                   host_issue;
    logic [1:0]             host_word;
    logic [SPAD_WORD_W-1:0] perf_val;

    assign host_ofs    = sys_addr_q - SYS_BASE;
    assign host_in_rng = (sys_addr_q >= SYS_BASE) && (host_ofs < SPAN);
    assign host_word   = sys_addr_q[3:2];
    assign host_issue  = (state_q == SPAD_PEND) && !acc_en;

    // RAM port
    logic                  ram_en;
    logic [SPAD_WORDS-1:0] ram_we;
    logic [AW-1:0]         ram_addr;
    logic [SPAD_ROW_W-1:0] ram_wdata;
    logic [SPAD_ROW_W-1:0] ram_rdata;

    spad_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // Port arbitration: accelerator first, host only in a PEND cycle the accelerator leaves idle.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = '0;
        ram_addr  = '0;
        ram_wdata = acc_wr_data;
        if (acc_en) begin
            ram_en   = acc_access && acc_in_rng;
            ram_addr = acc_ofs[AW+3:4];
            ram_we   = acc_rdwr ? acc_control[3:0] : '0;
        end else if (host_issue) begin
            ram_en    = host_in_rng;
            ram_addr  = host_ofs[AW+3:4];
            ram_we    = sys_wr_q ? (SPAD_WORDS'(1) << host_word) : '0;
            ram_wdata = {SPAD_WORDS{sys_wdat_q}};
        end
    end

    // Host FSM next state and status outputs.
    always_comb begin
        state_d   = state_q;
        sys_busy  = (state_q != SPAD_IDLE);
        sys_ready = (state_q == SPAD_RESP);
        case (state_q)
            SPAD_IDLE: if (sys_en)  state_d = SPAD_PEND;
            SPAD_PEND: if (!acc_en) state_d = SPAD_RESP;
            SPAD_RESP: state_d = SPAD_IDLE;
            default:   state_d = SPAD_IDLE;
        endcase
    end

    // Host FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= SPAD_IDLE;
        else      state_q <= state_d;
    end

    // Capture a host request only when idle; later sys_en pulses are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sys_addr_q <= '0;
            sys_wdat_q <= '0;
            sys_wr_q   <= 1'b0;
        end else if ((state_q == SPAD_IDLE) && sys_en) begin
            sys_addr_q <= sys_addr;
            sys_wdat_q <= sys_wr_data;
            sys_wr_q   <= sys_rdwr;
        end
    end

`ifdef TILE_SPAD_PERF_EN
    logic [31:0] perf_q;

    assign host_perf = (sys_addr_q >= SYS_BASE) && (host_ofs[31:2] == SPAN[31:2]);
    assign perf_val  = perf_q;

    // Saturating count of cycles the host waits behind the accelerator; host write clears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_q <= '0;
        end else if (host_issue && host_perf && sys_wr_q) begin
            perf_q <= '0;
        end else if ((state_q == SPAD_PEND) && acc_en && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end
`else
    assign host_perf = 1'b0;
    assign perf_val  = '0;
`endif

    // Accelerator read path: live RAM data the cycle after the read, held value otherwise.
    logic                  acc_rd_vld_q;
    logic                  acc_rd_oor_q;
    logic [SPAD_ROW_W-1:0] acc_hold_q;
    logic [SPAD_ROW_W-1:0] acc_rd_mux;

    assign acc_rd_mux  = acc_rd_vld_q ? (acc_rd_oor_q ? '0 : ram_rdata) : acc_hold_q;
    assign acc_rd_data = acc_rd_mux;

    // Track the outstanding accelerator read and latch its result for holding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_rd_vld_q <= 1'b0;
            acc_rd_oor_q <= 1'b0;
            acc_hold_q   <= '0;
        end else begin
            acc_rd_vld_q <= acc_rd;
            acc_rd_oor_q <= acc_rd && !acc_in_rng;
            if (acc_rd_vld_q) acc_hold_q <= acc_rd_mux;
        end
    end

    // Host read path: selected word in RESP, held value otherwise.
    logic [SPAD_WORD_W-1:0] sys_hold_q;
    logic [SPAD_WORD_W-1:0] host_rd_word;
    logic                   host_rd_done;

    assign host_rd_word = host_perf   ? perf_val :
                          host_in_rng ? ram_rdata[host_word*SPAD_WORD_W +: SPAD_WORD_W] : '0;
    assign host_rd_done = (state_q == SPAD_RESP) && !sys_wr_q;
    assign sys_rd_data  = host_rd_done ? host_rd_word : sys_hold_q;

    // Latch completed host read data so it holds until the next host read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              sys_hold_q <= '0;
        else if (host_rd_done) sys_hold_q <= host_rd_word;
    end

    // Sticky out-of-range flag from either port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if ((acc_access && !acc_in_rng) ||
                     (host_issue && !host_in_rng && !host_perf)) begin
            err <= 1'b1;
        end
    end

    logic unused_ctl;
    assign unused_ctl = acc_control[4];

endmodule

// File: tb/tb_tile_scratchpad.sv
module tb_tile_scratchpad;

    localparam int          DEPTH    = 64;
    localparam logic [31:0] ACC_BASE = 32'h0000_0000;
    localparam logic [31:0] SYS_BASE = 32'h4000_0000;
    localparam logic [31:0] SPAN     = 32'(DEPTH * 16);

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         acc_en = 1'b0;
    logic         acc_rdwr = 1'b0;
    logic [31:0]  acc_addr = '0;
    logic [4:0]   acc_control = '0;
    logic [127:0] acc_wr_data = '0;
    logic [127:0] acc_rd_data;
    logic         sys_en = 1'b0;
    logic         sys_rdwr = 1'b0;
    logic [31:0]  sys_addr = '0;
    logic [31:0]  sys_wr_data = '0;
    logic [31:0]  sys_rd_data;
    logic         sys_ready;
    logic         sys_busy;
    logic         err;

    tile_scratchpad #(.DEPTH(DEPTH), .ACC_BASE(ACC_BASE), .SYS_BASE(SYS_BASE)) dut (
        .clk         (clk),
        .rst         (rst),
        .acc_en      (acc_en),
        .acc_rdwr    (acc_rdwr),
        .acc_addr    (acc_addr),
        .acc_control (acc_control),
        .acc_wr_data (acc_wr_data),
        .acc_rd_data (acc_rd_data),
        .sys_en      (sys_en),
        .sys_rdwr    (sys_rdwr),
        .sys_addr    (sys_addr),
        .sys_wr_data (sys_wr_data),
        .sys_rd_data (sys_rd_data),
        .sys_ready   (sys_ready),
        .sys_busy    (sys_busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference storage: row x word, words numbered from the low end of the row.
    logic [31:0] mdl [DEPTH][4];

    function automatic logic [127:0] mrow(input int r);
        return {mdl[r][3], mdl[r][2], mdl[r][1], mdl[r][0]};
    endfunction

    function automatic logic acc_ok(input logic [31:0] a);
        return (a >= ACC_BASE) && ((a - ACC_BASE) < SPAN);
    endfunction

    function automatic logic sys_ok(input logic [31:0] a);
        return (a >= SYS_BASE) && ((a - SYS_BASE) < SPAN);
    endfunction

    function automatic logic [127:0] acc_exp(input logic [31:0] a);
        if (!acc_ok(a)) return '0;
        return mrow(int'((a - ACC_BASE) / 16));
    endfunction

    function automatic logic [31:0] sys_exp(input logic [31:0] a);
        logic [31:0] off;
        off = a - SYS_BASE;
        if (!sys_ok(a)) return '0;
        return mdl[int'(off / 16)][int'((off % 16) / 4)];
    endfunction

    task automatic chkr(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One accelerator access; on return the bench sits in the cycle where read data is due.
    task automatic acc_op(input logic wr, input logic [31:0] a, input logic [4:0] ctl, input logic [127:0] wd);
        acc_en      = 1'b1;
        acc_rdwr    = wr;
        acc_addr    = a;
        acc_control = ctl;
        acc_wr_data = wd;
        cyc();
        acc_en = 1'b0;
        if (wr && acc_ok(a)) begin
            for (int i = 0; i < 4; i++) begin
                if (ctl[i]) mdl[int'((a - ACC_BASE) / 16)][i] = wd[i*32 +: 32];
            end
        end
    endtask

    // Uncontended host access; checks the best-case two-cycle handshake.
    task automatic host_op(input logic wr, input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
        sys_en      = 1'b1;
        sys_rdwr    = wr;
        sys_addr    = a;
        sys_wr_data = wd;
        cyc();
        sys_en = 1'b0;
        chkb("host_busy", sys_busy, 1'b1);
        cyc();
        chkb("host_ready", sys_ready, 1'b1);
        rd = sys_rd_data;
        cyc();
        chkb("host_ready_drop", sys_ready, 1'b0);
        if (wr && sys_ok(a)) mdl[int'((a - SYS_BASE) / 16)][int'(((a - SYS_BASE) % 16) / 4)] = wd;
    endtask

    initial begin
        logic [31:0]  rd;
        logic [127:0] d;
        logic [127:0] acc_last;
        logic [31:0]  a;
        int           n;

        // Reset values
        #2;
        chkr("rst_acc_rd", acc_rd_data, '0);
        chkw("rst_sys_rd", sys_rd_data, '0);
        chkb("rst_ready", sys_ready, 1'b0);
        chkb("rst_busy", sys_busy, 1'b0);
        chkb("rst_err", err, 1'b0);
        cyc();
        rst = 1'b1;
        cyc();

        // Zero every row so the model is fully known.
        for (int r = 0; r < DEPTH; r++) acc_op(1'b1, ACC_BASE + 32'(r * 16), 5'h0F, '0);

        // Host preload then accelerator read
        host_op(1'b1, SYS_BASE + 32'h0, 32'h11111111, rd);
        host_op(1'b1, SYS_BASE + 32'h4, 32'h22222222, rd);
        host_op(1'b1, SYS_BASE + 32'h8, 32'h33333333, rd);
        host_op(1'b1, SYS_BASE + 32'hC, 32'h44444444, rd);
        acc_op(1'b0, ACC_BASE, 5'h0, '0);
        chkr("preload_acc", acc_rd_data, 128'h44444444_33333333_22222222_11111111);
        cyc();
        chkr("preload_hold", acc_rd_data, 128'h44444444_33333333_22222222_11111111);

        // Partial write, then a write with only the reserved control bit set
        d = '1;
        acc_op(1'b1, ACC_BASE + 32'h50, 5'b00101, d);
        host_op(1'b0, SYS_BASE + 32'h54, '0, rd);
        chkw("partial_w1", rd, 32'h0);
        host_op(1'b0, SYS_BASE + 32'h58, '0, rd);
        chkw("partial_w2", rd, 32'hFFFFFFFF);
        acc_op(1'b1, ACC_BASE + 32'h50, 5'b10000, '0);
        host_op(1'b0, SYS_BASE + 32'h50, '0, rd);
        chkw("noen_write", rd, 32'hFFFFFFFF);
        chkb("noen_err", err, 1'b0);
        chkr("host_no_disturb", acc_rd_data, 128'h44444444_33333333_22222222_11111111);

        // Read-after-write in consecutive cycles
        d = {$urandom, $urandom, $urandom, $urandom};
        acc_op(1'b1, ACC_BASE + 32'h70, 5'h0F, d);
        acc_op(1'b0, ACC_BASE + 32'h70, 5'h0, '0);
        chkr("raw", acc_rd_data, d);

        // Contention: accelerator holds the port for 6 cycles
        sys_en   = 1'b1;
        sys_rdwr = 1'b0;
        sys_addr = SYS_BASE + 32'h8;
        cyc();
        sys_en   = 1'b0;
        acc_en   = 1'b1;
        acc_rdwr = 1'b0;
        acc_addr = ACC_BASE;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chkb("cont_busy", sys_busy, 1'b1);
            chkb("cont_no_ready", sys_ready, 1'b0);
        end
        acc_en = 1'b0;
        cyc();
        chkb("cont_ready", sys_ready, 1'b1);
        chkw("cont_data", sys_rd_data, 32'h33333333);
        chkr("cont_acc_data", acc_rd_data, mrow(0));
        cyc();
        chkb("cont_idle", sys_busy, 1'b0);
`ifdef TILE_SPAD_PERF_EN
        host_op(1'b0, SYS_BASE + SPAN, '0, rd);
        chkw("perf_count", rd, 32'd6);
        host_op(1'b1, SYS_BASE + SPAN, '0, rd);
        host_op(1'b0, SYS_BASE + SPAN, '0, rd);
        chkw("perf_clear", rd, 32'd0);
        chkb("perf_no_err", err, 1'b0);
`endif

        // Dropped request: second sys_en in PEND and RESP is ignored
        sys_en   = 1'b1;
        sys_rdwr = 1'b0;
        sys_addr = SYS_BASE + 32'h4;
        cyc();
        n = 0;
        rd = '0;
        sys_rdwr    = 1'b1;
        sys_addr    = SYS_BASE + 32'hC;
        sys_wr_data = 32'hDEADBEEF;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) sys_en = 1'b0;
            if (sys_ready) begin
                n++;
                rd = sys_rd_data;
            end
            cyc();
        end
        chkw("drop_ready_count", 32'(n), 32'd1);
        chkw("drop_first_data", rd, 32'h22222222);
        host_op(1'b0, SYS_BASE + 32'hC, '0, rd);
        chkw("drop_not_written", rd, sys_exp(SYS_BASE + 32'hC));

        // Out-of-range accesses
        chkb("oor_err_before", err, 1'b0);
        acc_op(1'b0, ACC_BASE + SPAN, 5'h0, '0);
        chkr("oor_acc_data", acc_rd_data, '0);
        chkb("oor_err_set", err, 1'b1);
        host_op(1'b0, SYS_BASE - 32'h4, '0, rd);
        chkw("oor_host_low", rd, 32'h0);
        host_op(1'b1, SYS_BASE + SPAN + 32'h10, 32'h12345678, rd);
        acc_last = '0;

        // Randomized traffic against the model
        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    if ($urandom_range(0, 7) == 0) a = ACC_BASE + SPAN + 32'($urandom_range(0, 15) * 16);
                    else a = ACC_BASE + 32'($urandom_range(0, DEPTH - 1) * 16) + 32'($urandom_range(0, 15));
                    acc_op(1'b0, a, 5'($urandom_range(0, 31)), '0);
                    acc_last = acc_exp(a);
                    chkr("rand_acc_rd", acc_rd_data, acc_last);
                end
                1: begin
                    a = ACC_BASE + 32'($urandom_range(0, DEPTH - 1) * 16);
                    acc_op(1'b1, a, 5'($urandom_range(0, 31)), {$urandom, $urandom, $urandom, $urandom});
                end
                2: begin
                    if ($urandom_range(0, 7) == 0) a = SYS_BASE - 32'($urandom_range(1, 8) * 4);
                    else a = SYS_BASE + 32'($urandom_range(0, DEPTH * 4 - 1) * 4);
                    host_op(1'b0, a, '0, rd);
                    chkw("rand_host_rd", rd, sys_exp(a));
                    chkr("rand_acc_hold", acc_rd_data, acc_last);
                end
                default: begin
                    if ($urandom_range(0, 7) == 0) a = SYS_BASE + SPAN + 32'($urandom_range(1, 8) * 16);
                    else a = SYS_BASE + 32'($urandom_range(0, DEPTH * 4 - 1) * 4);
                    host_op(1'b1, a, $urandom, rd);
                end
            endcase
        end
        chkb("err_sticky", err, 1'b1);

        // Reset while a host request is pending
        sys_en   = 1'b1;
        sys_rdwr = 1'b0;
        sys_addr = SYS_BASE;
        cyc();
        sys_en   = 1'b0;
        acc_en   = 1'b1;
        acc_rdwr = 1'b0;
        acc_addr = ACC_BASE;
        cyc();
        chkb("mid_busy", sys_busy, 1'b1);
        #2;
        rst = 1'b0;
        acc_en = 1'b0;
        #1;
        chkr("mid_rst_acc_rd", acc_rd_data, '0);
        chkw("mid_rst_sys_rd", sys_rd_data, '0);
        chkb("mid_rst_ready", sys_ready, 1'b0);
        chkb("mid_rst_busy", sys_busy, 1'b0);
        chkb("mid_rst_err", err, 1'b0);
        cyc();
        cyc();
        rst = 1'b1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (sys_ready) n++;
        end
        chkw("mid_rst_no_ready", 32'(n), 32'd0);
        chkb("mid_rst_idle", sys_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
